data_mem_requester: RTL and testbench

- Load/store requester that drives the DataMemory port (adr, datain, w, r, dataout) on behalf of the pipeline.
- Accepts one byte/half/word/doubleword load or store at a time over a valid/ready handshake.
- Stores narrower than 64 bits use read-modify-write on the 64-bit memory word.
- Loads return a zero- or sign-extended result with a one-cycle response pulse.

---
 rtl/data_mem_requester.sv | 194 +++++++++++++++++++
 tb/tb_data_mem_requester.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_requester.sv
// Load/store requester for the 64-bit DataMemory port: one request at a time,
// read-modify-write for sub-doubleword stores, sign/zero-extended loads.
module data_mem_requester #(
  parameter int MEM_RD_LAT = 1,
  parameter int ADDR_W     = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [63:0]       mem_datain,
  output logic              mem_w,
  output logic              mem_r,
  input  logic [63:0]       mem_dataout,
  output logic [2:0]        dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, so requests presented while busy just wait.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_RWAIT = 3'd2,
    S_WR    = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  localparam logic [1:0] CNT_INIT = 2'(MEM_RD_LAT - 1);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [2:0]          off_q, off_d;
  logic [63:0]         wdata_q, wdata_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [63:0]         resp_rdata_q, resp_rdata_d;
  logic [ADDR_W-1:0]   mem_adr_q, mem_adr_d;
  logic [63:0]         mem_datain_q, mem_datain_d;

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
  endfunction

  function automatic logic [63:0] lane_mask(input logic [1:0] size);
    case (size)
      2'd0:    lane_mask = 64'h0000_0000_0000_00FF;
      2'd1:    lane_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    lane_mask = 64'h0000_0000_FFFF_FFFF;
      default: lane_mask = '1;
    endcase
  endfunction

  // Replace the addressed lane of the memory word with the low bytes of wdata.
  function automatic logic [63:0] merge_store(input logic [63:0] word, input logic [63:0] wdata,
                                              input logic [2:0] off, input logic [1:0] size);
    logic [63:0] m;
    m = lane_mask(size);
    merge_store = (word & ~(m << {off, 3'b000})) | ((wdata & m) << {off, 3'b000});
  endfunction

  function automatic logic [63:0] load_extend(input logic [63:0] word, input logic [2:0] off,
                                              input logic [1:0] size, input logic uns);
    logic [63:0] s;
    s = word >> {off, 3'b000};
    case (size)
      2'd0:    load_extend = uns ? {56'b0, s[7:0]}  : {{56{s[7]}}, s[7:0]};
      2'd1:    load_extend = uns ? {48'b0, s[15:0]} : {{48{s[15]}}, s[15:0]};
      2'd2:    load_extend = uns ? {32'b0, s[31:0]} : {{32{s[31]}}, s[31:0]};
      default: load_extend = s;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    resp_rdata_d = resp_rdata_q;
    mem_adr_d    = mem_adr_q;
    mem_datain_d = mem_datain_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          off_d   = req_addr[2:0];
          wdata_d = req_wdata;
          err_d   = misaligned(req_size, req_addr[2:0]);
          if (err_d) begin
            resp_rdata_d = '0;
            state_d      = S_RESP;
          end else begin
            mem_adr_d = {3'b000, req_addr[ADDR_W-1:3]};
            if (req_we && (req_size == 2'd3)) begin
              mem_datain_d = req_wdata;
              state_d      = S_WR;
            end else begin
              state_d = S_RD;
            end
          end
        end
      end
      S_RD: begin
        cnt_d   = CNT_INIT;
        state_d = S_RWAIT;
      end
      S_RWAIT: begin
        if (cnt_q == 2'd0) begin
          // Memory word is valid in this last wait cycle; consume it at the edge.
          if (we_q) begin
            mem_datain_d = merge_store(mem_dataout, wdata_q, off_q, size_q);
            state_d      = S_WR;
          end else begin
            resp_rdata_d = load_extend(mem_dataout, off_q, size_q, uns_q);
            state_d      = S_RESP;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_WR: begin
        resp_rdata_d = '0;
        state_d      = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      off_q        <= 3'd0;
      wdata_q      <= '0;
      cnt_q        <= 2'd0;
      err_q        <= 1'b0;
      resp_rdata_q <= '0;
      mem_adr_q    <= '0;
      mem_datain_q <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_adr_q    <= mem_adr_d;
      mem_datain_q <= mem_datain_d;
    end
  end

  // Strobes decode straight from the state register so reset kills them at once.
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = (state_q == S_RESP) && err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_r      = (state_q == S_RD);
  assign mem_w      = (state_q == S_WR);
  assign mem_adr    = mem_adr_q;
  assign mem_datain = mem_datain_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_data_mem_requester.sv
// Bench for data_mem_requester: DataMemory stand-in, transaction-level reference
// model with a per-cycle compare process, directed scenarios and random traffic.
module tb_data_mem_requester;

  localparam int LAT = 1;
  localparam int AW  = 64;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [63:0]   req_wdata;
  logic          resp_valid, resp_err, mem_w, mem_r;
  logic [63:0]   resp_rdata, mem_datain, mem_dataout;
  logic [AW-1:0] mem_adr;
  logic [2:0]    dbg_state;

  data_mem_requester #(.MEM_RD_LAT(LAT), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_adr(mem_adr), .mem_datain(mem_datain), .mem_w(mem_w), .mem_r(mem_r),
    .mem_dataout(mem_dataout), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [63:0] init_word(int i);
    return 64'h9E37_79B9_7F4A_7C15 * 64'(i + 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t state=%0d)", name, act, exp, $time, dbg_state);
    end
  endtask

  // ---------------- DataMemory stand-in (16 words, read latency 1) ----------------
  logic [63:0] env_mem [16];
  bit env_init = 1'b0;
  always @(posedge clk) begin
    if (!env_init) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= init_word(i);
      mem_dataout <= '0;
      env_init    <= 1'b1;
    end else begin
      if (mem_w) env_mem[mem_adr[3:0]] <= mem_datain;
      if (mem_r) mem_dataout <= env_mem[mem_adr[3:0]];
    end
  end

  // ---------------- reference model ----------------
  logic [63:0] ref_mem [16];
  logic [63:0] exp_q[$];
  bit          busy = 1'b0;
  int          cyc = 0, m_lat = 0, m_rd = 0, m_wr = 0, m_idx = 0;
  bit          m_err = 1'b0;
  logic [63:0] m_din = '0;
  logic [63:0] held_rdata = '0;
  logic [63:0] held_adr = '0;

  task automatic model_accept();
    int n, off;
    logic [63:0] w, v, keep;
    n     = 1 << req_size;
    off   = int'(req_addr[2:0]);
    m_idx = int'(req_addr[6:3]);
    m_err = (off % n) != 0;
    m_rd  = 0;
    m_wr  = 0;
    m_din = '0;
    w     = ref_mem[m_idx];
    if (m_err) begin
      m_lat = 1;
      exp_q.push_back(64'd0);
    end else begin
      held_adr = req_addr >> 3;
      if (req_we) begin
        exp_q.push_back(64'd0);
        if (n == 8) begin
          m_lat = 2; m_wr = 1; m_din = req_wdata;
        end else begin
          m_lat = LAT + 3; m_rd = 1; m_wr = LAT + 2; m_din = w;
          for (int b = 0; b < n; b++) m_din[8*(off+b) +: 8] = req_wdata[8*b +: 8];
        end
      end else begin
        m_lat = LAT + 2; m_rd = 1;
        v = w >> (8 * off);
        if (n < 8) begin
          keep = (64'd1 << (8 * n)) - 64'd1;
          v = v & keep;
          if (!req_unsigned && v[8*n-1]) v = v | ~keep;
        end
        exp_q.push_back(v);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        busy = 1'b0; held_rdata = '0; held_adr = '0; exp_q.delete();
      end else if (busy) begin
        if (cyc == m_wr) ref_mem[m_idx] = m_din;
        if (cyc == m_lat) begin
          busy = 1'b0;
          held_rdata = exp_q.pop_front();
        end else begin
          cyc++;
        end
      end else if (req_valid) begin
        model_accept();
        busy = 1'b1;
        cyc  = 1;
      end
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mem_r", mem_r, 0);
        chk("rst_mem_w", mem_w, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_mem_adr", mem_adr, 0);
        chk("rst_mem_datain", mem_datain, 0);
      end else begin
        chk("req_ready", req_ready, !busy);
        chk("mem_r", mem_r, busy && cyc == m_rd);
        chk("mem_w", mem_w, busy && cyc == m_wr);
        chk("resp_valid", resp_valid, busy && cyc == m_lat);
        chk("resp_err", resp_err, (busy && cyc == m_lat) ? m_err : 1'b0);
        chk("resp_rdata", resp_rdata, (busy && cyc == m_lat && exp_q.size() > 0) ? exp_q[0] : held_rdata);
        chk("mem_adr", mem_adr, held_adr);
        if (busy && cyc == m_wr) chk("mem_datain", mem_datain, m_din);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [63:0] addr, input logic [63:0] wdata);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < 30 && !acc; k++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
    end
    chk(name, acc, 1);
  endtask

  task automatic do_req(input bit we, input logic [1:0] sz, input bit uns,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        output int lat, output logic [63:0] rdata, output bit err);
    set_req(we, sz, uns, addr, wdata);
    wait_accept("accept_timeout");
    req_valid = 1'b0;
    lat = 0; rdata = '0; err = 1'b0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      if (resp_valid) begin lat = c; rdata = resp_rdata; err = resp_err; end
    end
    if (lat == 0) chk("resp_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic abort_req(input bit we, input logic [1:0] sz, input logic [63:0] addr,
                           input logic [63:0] wdata, input int at_cyc,
                           input bit pre_r, input bit pre_w);
    set_req(we, sz, 1'b0, addr, wdata);
    wait_accept("abort_accept");
    req_valid = 1'b0;
    repeat (at_cyc - 1) @(posedge clk);
    #2;
    chk("pre_rst_mem_r", mem_r, pre_r);
    chk("pre_rst_mem_w", mem_w, pre_w);
    rst_n = 1'b0;
    #1;
    chk("async_mem_r", mem_r, 0);
    chk("async_mem_w", mem_w, 0);
    chk("async_resp_valid", resp_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", req_ready, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          lat, n_resp, take_c;
    logic [63:0] rdata;
    bit          err, take, acc;
    int          rcyc [2];
    logic [63:0] rdat [2];
    logic [1:0]  sz;
    logic [63:0] addr;

    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", req_ready, 1);

    // full store
    do_req(1'b1, 2'd3, 1'b0, 64'h50, 64'h0123_4567_89AB_CDEF, lat, rdata, err);
    chk("st64_latency", lat, 2);
    chk("st64_err", err, 0);
    chk("st64_rdata", rdata, 0);
    chk("st64_mem", env_mem[10], 64'h0123_4567_89AB_CDEF);

    // byte loads, signed then unsigned
    do_req(1'b0, 2'd0, 1'b0, 64'h53, 64'h0, lat, rdata, err);
    chk("ldb_s_latency", lat, 3);
    chk("ldb_s_rdata", rdata, 64'hFFFF_FFFF_FFFF_FF89);
    do_req(1'b0, 2'd0, 1'b1, 64'h53, 64'h0, lat, rdata, err);
    chk("ldb_u_latency", lat, 3);
    chk("ldb_u_rdata", rdata, 64'h0000_0000_0000_0089);

    // half store by read-modify-write, then read back
    do_req(1'b1, 2'd1, 1'b0, 64'h52, 64'hBEEF, lat, rdata, err);
    chk("sth_latency", lat, 4);
    chk("sth_mem", env_mem[10], 64'h0123_4567_BEEF_CDEF);
    do_req(1'b0, 2'd3, 1'b0, 64'h50, 64'h0, lat, rdata, err);
    chk("ld64_latency", lat, 3);
    chk("ld64_rdata", rdata, 64'h0123_4567_BEEF_CDEF);

    // misaligned word load
    do_req(1'b0, 2'd2, 1'b0, 64'h56, 64'h0, lat, rdata, err);
    chk("mis_latency", lat, 1);
    chk("mis_err", err, 1);
    chk("mis_rdata", rdata, 0);

    // resets in RWAIT of a partial store, in RD of a load, in WR of a full store
    abort_req(1'b1, 2'd1, 64'h50, 64'h1111, 2, 1'b0, 1'b0);
    abort_req(1'b0, 2'd3, 64'h58, 64'h0, 1, 1'b1, 1'b0);
    abort_req(1'b1, 2'd3, 64'h60, 64'hDEAD_BEEF_0000_0001, 1, 1'b0, 1'b1);
    chk("abort_mem_0a", env_mem[10], 64'h0123_4567_BEEF_CDEF);
    chk("abort_mem_0c", env_mem[12], init_word(12));

    // two loads queued back-to-back with req_valid held high
    set_req(1'b0, 2'd2, 1'b1, 64'h50, 64'h0);
    wait_accept("b2b_accept");
    set_req(1'b0, 2'd3, 1'b0, 64'h60, 64'h0);
    n_resp = 0; take_c = 0;
    rcyc[0] = 0; rcyc[1] = 0; rdat[0] = '0; rdat[1] = '0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        if (n_resp < 2) begin rcyc[n_resp] = c; rdat[n_resp] = resp_rdata; end
        n_resp++;
      end
      take = req_ready && req_valid;
      if (take) take_c = c;
      @(posedge clk);
      #1;
      if (take) req_valid = 1'b0;
    end
    chk("b2b_resp_count", n_resp, 2);
    chk("b2b_second_accept", take_c, rcyc[0] + 1);
    chk("b2b_resp_gap", rcyc[1] - rcyc[0], 4);
    chk("b2b_rdata0", rdat[0], 64'h0000_0000_BEEF_CDEF);
    chk("b2b_rdata1", rdat[1], init_word(12));

    // random traffic
    for (int t = 0; t < 300; t++) begin
      sz   = 2'($urandom_range(0, 3));
      addr = 64'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << sz) - 64'd1);
      set_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, {$urandom, $urandom});
      acc = 1'b0;
      for (int k = 0; k < 30 && !acc; k++) begin
        @(negedge clk);
        acc = req_ready;
        @(posedge clk);
        #1;
      end
      chk("rand_accept", acc, 1);
      if ($urandom_range(0, 1) == 1) begin
        req_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    end
    req_valid = 1'b0;
    for (int k = 0; k < 20 && busy; k++) @(posedge clk);
    chk("drain_idle", busy, 0);
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d mismatched=%0d", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
